i2c_tof_target: RTL and testbench

- I2C target (responder) that mimics the register interface of one ToF sensor, with 7-bit device address and 16-bit register addressing.
- Bench/loop-back partner for the ToF I2C initiator modules. Also used as an on-FPGA sensor emulator, where register reads are served from a BRAM port and register writes are forwarded as strobes.
- Drives an open-drain SDA and an active-low INT line, matching the sensor pinout.

---
 rtl/i2c_tof_target.sv | 260 ++++++++++++++++++++++++++
 tb/tb_i2c_tof_target.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_tof_target.sv
// I2C target emulating a ToF sensor register map: 7-bit device address, 16-bit register pointer,
// reads served from a fixed-latency BRAM port, writes forwarded as strobes, active-low interrupt.
module i2c_tof_target #(
   parameter logic [6:0]  DEV_ADDR     = 7'h29,
   parameter int unsigned RD_LATENCY   = 2,
   parameter logic [15:0] INT_CLR_ADDR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe,
   output logic [15:0] reg_addr,
   output logic [7:0]  wr_data,
   output logic        wr_en,
   output logic        rd_req,
   input  logic [7:0]  rd_data,
   input  logic        int_set,
   output logic        int_n,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_ADDR, REG_HI, ACK_HI, REG_LO, ACK_LO,
      WR_DATA, ACK_WR, RD_DATA, RD_MACK
   } state_t;

   localparam int LD_W = $clog2(RD_LATENCY + 2);
   // Counter reaches 1 in the cycle where rd_data is valid, RD_LATENCY cycles after rd_req.
   localparam logic [LD_W-1:0] LD_INIT = LD_W'(RD_LATENCY + 1);

   logic [1:0]      scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic [2:0]      scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
   logic            scl_f_q, scl_f_d, sda_f_q, sda_f_d;
   logic            scl_rise, scl_fall, bus_start, bus_stop;

   state_t          state_q, state_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      sh_q, sh_d;
   logic [7:0]      hi_q, hi_d;
   logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
   logic            rw_q, rw_d;
   logic            mack_q, mack_d;
   logic            sda_oe_q, sda_oe_d;
   logic [15:0]     reg_addr_q, reg_addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic            wr_en_q, wr_en_d;
   logic            rd_req_q, rd_req_d;
   logic            pending_q, pending_d;
   logic            busy_q, busy_d;
   logic            int_clr;

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_i};
      sda_sync_d = {sda_sync_q[0], sda_i};
      scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
      scl_f_d = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2])
              | (scl_hist_q[1] & scl_hist_q[2]);
      sda_f_d = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2])
              | (sda_hist_q[1] & sda_hist_q[2]);
   end

   assign scl_rise  = scl_f_d & ~scl_f_q;
   assign scl_fall  = ~scl_f_d & scl_f_q;
   assign bus_start = scl_f_d & scl_f_q & sda_f_q & ~sda_f_d;
   assign bus_stop  = scl_f_d & scl_f_q & ~sda_f_q & sda_f_d;

   always_comb begin
      // NOTE: every variable gets its hold/default value first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      hi_d       = hi_q;
      ld_cnt_d   = ld_cnt_q;
      rw_d       = rw_q;
      mack_d     = mack_q;
      sda_oe_d   = sda_oe_q;
      reg_addr_d = reg_addr_q;
      wr_data_d  = wr_data_q;
      wr_en_d    = 1'b0;
      rd_req_d   = 1'b0;
      busy_d     = busy_q;
      int_clr    = 1'b0;

      if (ld_cnt_q != '0) begin
         ld_cnt_d = ld_cnt_q - LD_W'(1);
         if (ld_cnt_q == LD_W'(1)) begin
            sh_d     = rd_data;
            sda_oe_d = ~rd_data[7];
         end
      end

      if (bus_start) begin
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         ld_cnt_d  = '0;
      end else if (bus_stop) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         ld_cnt_d = '0;
      end else begin
         case (state_q)
            ADDR, REG_HI, REG_LO, WR_DATA: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  sh_d      = {sh_q[6:0], sda_f_d};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = 1'b1;
                  case (state_q)
                     ADDR: begin
                        if (sh_q[7:1] == DEV_ADDR) begin
                           state_d = ACK_ADDR;
                           busy_d  = 1'b1;
                           rw_d    = sh_q[0];
                        end else begin
                           state_d  = IDLE;
                           sda_oe_d = 1'b0;
                        end
                     end
                     REG_HI: begin
                        hi_d    = sh_q;
                        state_d = ACK_HI;
                     end
                     REG_LO:  state_d = ACK_LO;
                     default: begin
                        wr_data_d = sh_q;
                        wr_en_d   = 1'b1;
                        state_d   = ACK_WR;
                     end
                  endcase
               end
            end
            ACK_ADDR, ACK_HI, ACK_LO, ACK_WR: begin
               // bit_cnt marks that the ACK clock pulse has been seen, so the next fall ends it.
               if (scl_rise) begin
                  bit_cnt_d = 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = 1'b0;
                  case (state_q)
                     ACK_ADDR: begin
                        if (rw_q) begin
                           state_d  = RD_DATA;
                           rd_req_d = 1'b1;
                           ld_cnt_d = LD_INIT;
                        end else begin
                           state_d = REG_HI;
                        end
                     end
                     ACK_HI: state_d = REG_LO;
                     ACK_LO: begin
                        reg_addr_d = {hi_q, sh_q};
                        state_d    = WR_DATA;
                     end
                     default: begin
                        reg_addr_d = reg_addr_q + 16'd1;
                        state_d    = WR_DATA;
                     end
                  endcase
               end
            end
            RD_DATA: begin
               if (scl_fall && ld_cnt_q == '0) begin
                  if (bit_cnt_q == 4'd7) begin
                     state_d   = RD_MACK;
                     bit_cnt_d = 4'd0;
                     sda_oe_d  = 1'b0;
                  end else begin
                     sh_d      = {sh_q[6:0], 1'b0};
                     sda_oe_d  = ~sh_q[6];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            RD_MACK: begin
               if (scl_rise) begin
                  bit_cnt_d  = 4'd1;
                  mack_d     = ~sda_f_d;
                  reg_addr_d = reg_addr_q + 16'd1;
                  int_clr    = (reg_addr_q == INT_CLR_ADDR);
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  bit_cnt_d = 4'd0;
                  if (mack_q) begin
                     state_d  = RD_DATA;
                     rd_req_d = 1'b1;
                     ld_cnt_d = LD_INIT;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: ;
         endcase
      end

      pending_d = pending_q;
      if (int_clr) pending_d = 1'b0;
      if (int_set) pending_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 3'b111;
         sda_hist_q <= 3'b111;
         scl_f_q    <= 1'b1;
         sda_f_q    <= 1'b1;
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         sh_q       <= 8'h00;
         hi_q       <= 8'h00;
         ld_cnt_q   <= '0;
         rw_q       <= 1'b0;
         mack_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         reg_addr_q <= 16'h0000;
         wr_data_q  <= 8'h00;
         wr_en_q    <= 1'b0;
         rd_req_q   <= 1'b0;
         pending_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
         scl_f_q    <= scl_f_d;
         sda_f_q    <= sda_f_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         hi_q       <= hi_d;
         ld_cnt_q   <= ld_cnt_d;
         rw_q       <= rw_d;
         mack_q     <= mack_d;
         sda_oe_q   <= sda_oe_d;
         reg_addr_q <= reg_addr_d;
         wr_data_q  <= wr_data_d;
         wr_en_q    <= wr_en_d;
         rd_req_q   <= rd_req_d;
         pending_q  <= pending_d;
         busy_q     <= busy_d;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign reg_addr = reg_addr_q;
   assign wr_data  = wr_data_q;
   assign wr_en    = wr_en_q;
   assign rd_req   = rd_req_q;
   assign int_n    = ~pending_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_tof_target.sv
// Testbench for i2c_tof_target: bit-banged I2C initiator, 2-cycle BRAM read model, write/read logs.
`timescale 1ns/1ps
module tb_i2c_tof_target;

   localparam int T = 8;  // clk cycles per quarter SCL period

   typedef struct {
      logic [7:0]  addr_byte;
      logic [15:0] ptr;
      int          n;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic        exp_ack;
      logic [15:0] exp_wa0;
      logic [15:0] exp_wa1;
      logic [15:0] exp_addr;
   } wr_vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m_scl = 1'b1;
   logic        m_sda_low = 1'b0;
   logic        sda_line;
   logic        sda_oe;
   logic [15:0] reg_addr;
   logic [7:0]  wr_data;
   logic        wr_en;
   logic        rd_req;
   logic [7:0]  rd_data = 8'h00;
   logic [7:0]  rd_p1 = 8'h00;
   logic        int_set = 1'b0;
   logic        int_n;
   logic        busy;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [23:0] wr_log[$];
   logic [15:0] rd_log[$];
   logic        oe_seen = 1'b0;
   logic        int_watch = 1'b0;
   logic        int_glitch = 1'b0;
   wr_vec_t     vecs[4];

   assign sda_line = ~(m_sda_low | sda_oe);

   i2c_tof_target dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl_i    (m_scl),
      .sda_i    (sda_line),
      .sda_oe   (sda_oe),
      .reg_addr (reg_addr),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .int_set  (int_set),
      .int_n    (int_n),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      case (a)
         16'h0100: return 8'h11;
         16'h0101: return 8'h22;
         16'h0102: return 8'h33;
         16'h0000: return 8'h5A;
         default:  return 8'hC3;
      endcase
   endfunction

   // Two-stage BRAM: data valid exactly two cycles after rd_req, garbage otherwise.
   always @(posedge clk) begin
      rd_p1   <= rd_req ? mem_rd(reg_addr) : 8'hE7;
      rd_data <= rd_p1;
   end

   always @(negedge clk) begin
      if (wr_en) wr_log.push_back({reg_addr, wr_data});
      if (rd_req) rd_log.push_back(reg_addr);
      if (sda_oe) oe_seen = 1'b1;
      if (int_watch && int_n) int_glitch = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0;
      wait_clk(T);
      m_scl = 1'b1;
      wait_clk(T);
      m_sda_low = 1'b1;
      wait_clk(T);
      m_scl = 1'b0;
      wait_clk(T);
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1;
      wait_clk(T);
      m_scl = 1'b1;
      wait_clk(T);
      m_sda_low = 1'b0;
      wait_clk(T);
   endtask

   task automatic send_bit(input logic b, output logic rb);
      m_sda_low = ~b;
      wait_clk(T);
      m_scl = 1'b1;
      wait_clk(T);
      rb = sda_line;
      wait_clk(T);
      m_scl = 1'b0;
      wait_clk(T);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) send_bit(b[i], r);
      send_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      logic r;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1, r);
         b = {b[6:0], r};
      end
      send_bit(~mack, r);
   endtask

   task automatic set_ptr_then_read(input logic [15:0] ptr);
      logic ack;
      bus_start();
      write_byte(8'h52, ack);
      write_byte(ptr[15:8], ack);
      write_byte(ptr[7:0], ack);
      bus_start();
      write_byte(8'h53, ack);
      check("rd_addr_ack", 32'(ack), 32'd1);
   endtask

   task automatic pulse_int_set();
      int_set = 1'b1;
      wait_clk(1);
      int_set = 1'b0;
      wait_clk(2);
   endtask

   task automatic do_write(input wr_vec_t v);
      logic       ack;
      logic [7:0] db;
      logic [23:0] exp_e;
      wr_log.delete();
      oe_seen = 1'b0;
      bus_start();
      write_byte(v.addr_byte, ack);
      check("addr_ack", 32'(ack), 32'(v.exp_ack));
      check("busy_after_addr", 32'(busy), 32'(v.exp_ack));
      write_byte(v.ptr[15:8], ack);
      check("ptr_hi_ack", 32'(ack), 32'(v.exp_ack));
      write_byte(v.ptr[7:0], ack);
      check("ptr_lo_ack", 32'(ack), 32'(v.exp_ack));
      for (int i = 0; i < v.n; i++) begin
         db = (i == 0) ? v.d0 : v.d1;
         write_byte(db, ack);
         check("data_ack", 32'(ack), 32'(v.exp_ack));
      end
      bus_stop();
      wait_clk(T);
      check("busy_after_stop", 32'(busy), 32'd0);
      check("reg_addr_final", 32'(reg_addr), 32'(v.exp_addr));
      check("wr_en_count", 32'(wr_log.size()), v.exp_ack ? 32'(v.n) : 32'd0);
      for (int i = 0; i < wr_log.size(); i++) begin
         exp_e = (i == 0) ? {v.exp_wa0, v.d0} : {v.exp_wa1, v.d1};
         check("wr_en_addr_data", 32'(wr_log[i]), 32'(exp_e));
      end
      if (!v.exp_ack) check("no_sda_drive", 32'(oe_seen), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      logic       r;

      vecs[0] = '{8'h52, 16'h2C04, 2, 8'hA5, 8'h3C, 1'b1, 16'h2C04, 16'h2C05, 16'h2C06};
      vecs[1] = '{8'h54, 16'h1234, 2, 8'h99, 8'h66, 1'b0, 16'h0000, 16'h0000, 16'h2C06};
      vecs[2] = '{8'h52, 16'hFFFF, 2, 8'h01, 8'h02, 1'b1, 16'hFFFF, 16'h0000, 16'h0001};
      vecs[3] = '{8'h52, 16'h0010, 1, 8'h77, 8'h00, 1'b1, 16'h0010, 16'h0000, 16'h0011};

      wait_clk(5);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_reg_addr", 32'(reg_addr), 32'd0);
      check("rst_strobes", 32'({wr_en, rd_req, wr_data}), 32'd0);
      check("rst_int_n", 32'(int_n), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      wait_clk(4 * T);

      for (int i = 0; i < 3; i++) do_write(vecs[i]);

      // Pointer write, repeated START, sequential read of three bytes.
      rd_log.delete();
      set_ptr_then_read(16'h0100);
      read_byte(1'b1, b);
      check("rd_byte0", 32'(b), 32'h11);
      read_byte(1'b1, b);
      check("rd_byte1", 32'(b), 32'h22);
      read_byte(1'b0, b);
      check("rd_byte2", 32'(b), 32'h33);
      check("sda_released_after_nack", 32'(sda_oe), 32'd0);
      bus_stop();
      wait_clk(T);
      check("rd_req_count", 32'(rd_log.size()), 32'd3);
      for (int i = 0; i < rd_log.size(); i++)
         check("rd_req_addr", 32'(rd_log[i]), 32'h0100 + 32'(i));
      check("rd_reg_addr_final", 32'(reg_addr), 32'h0103);
      check("rd_busy_after_stop", 32'(busy), 32'd0);

      // Interrupt set, then cleared by a completed read of INT_CLR_ADDR.
      pulse_int_set();
      check("int_n_set", 32'(int_n), 32'd0);
      set_ptr_then_read(16'h0000);
      read_byte(1'b0, b);
      check("int_rd_byte", 32'(b), 32'h5A);
      check("int_n_cleared", 32'(int_n), 32'd1);
      bus_stop();

      // Set held across the clearing cycle: set must win.
      pulse_int_set();
      set_ptr_then_read(16'h0000);
      for (int i = 0; i < 8; i++) send_bit(1'b1, r);
      int_glitch = 1'b0;
      int_set = 1'b1;
      int_watch = 1'b1;
      send_bit(1'b1, r);
      int_set = 1'b0;
      wait_clk(2);
      int_watch = 1'b0;
      check("int_set_wins_glitch", 32'(int_glitch), 32'd0);
      check("int_n_still_set", 32'(int_n), 32'd0);
      bus_stop();

      // Reset during the 5th bit of a read byte (0x33: that bit is 0, so SDA is driven).
      set_ptr_then_read(16'h0102);
      for (int i = 0; i < 4; i++) send_bit(1'b1, r);
      m_sda_low = 1'b0;
      wait_clk(T);
      m_scl = 1'b1;
      wait_clk(T);
      check("rd_bit5_driven", 32'(sda_oe), 32'd1);
      check("int_n_before_rst", 32'(int_n), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_reg_addr", 32'(reg_addr), 32'd0);
      check("async_rst_int_n", 32'(int_n), 32'd1);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4 * T);
      do_write(vecs[3]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
